// File: rtl/seq_normalizer_if.sv
// Valid/ready operand and result bundle for the left-shift normalizer.
// The master side feeds operands and accepts results; the slave side is the normalizer.
interface seq_normalizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic [EXP_WIDTH-1:0]  exp_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic [EXP_WIDTH-1:0]  exp_out;
    logic [CNT_W-1:0]      shift_cnt;
    logic                  zero;
    logic                  denorm;

    modport master (
        output in_valid, data_in, exp_in, out_ready,
        input  in_ready, out_valid, data_out, exp_out, shift_cnt, zero, denorm
    );

    modport slave (
        input  in_valid, data_in, exp_in, out_ready,
        output in_ready, out_valid, data_out, exp_out, shift_cnt, zero, denorm
    );
endinterface

// File: rtl/seq_normalizer.sv
// Iterative left-shift normalizer: shifts the mantissa up until its MSB is set or the
// exponent bottoms out at 1, one shift action per cycle, one operand in flight.
module seq_normalizer #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int STEP       = 1,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input logic              clk,
    input logic              rst_n,
    seq_normalizer_if.slave  bus
);
    generate
        if (DATA_WIDTH < 4 || !(STEP == 1 || STEP == 2 || STEP == 4) || STEP >= DATA_WIDTH) begin : g_bad_cfg
            $error("seq_normalizer: illegal DATA_WIDTH/STEP combination");
        end
    endgenerate

    localparam int                   MSB    = DATA_WIDTH - 1;
    localparam logic [EXP_WIDTH-1:0] STEP_E = EXP_WIDTH'(STEP);
    localparam logic [EXP_WIDTH-1:0] ONE_E  = EXP_WIDTH'(1);
    localparam logic [CNT_W-1:0]     STEP_C = CNT_W'(STEP);
    localparam logic [CNT_W-1:0]     ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] m, m_d;
    logic [EXP_WIDTH-1:0]  e, e_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  ld;
    logic [EXP_WIDTH-1:0]  exp_o_d;
    logic                  zero_d, denorm_d;
    logic                  top_zero;

    assign top_zero      = (m[MSB -: STEP] == '0);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m     <= '0;
            e     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            m     <= m_d;
            e     <= e_d;
            cnt   <= cnt_d;
        end
    end

    // Result registers load once on entry to DONE and then hold, even past the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out  <= '0;
            bus.exp_out   <= '0;
            bus.shift_cnt <= '0;
            bus.zero      <= 1'b0;
            bus.denorm    <= 1'b0;
        end else if (ld) begin
            bus.data_out  <= m;
            bus.exp_out   <= exp_o_d;
            bus.shift_cnt <= cnt;
            bus.zero      <= zero_d;
            bus.denorm    <= denorm_d;
        end
    end

    always_comb begin
        state_d  = state;
        m_d      = m;
        e_d      = e;
        cnt_d    = cnt;
        ld       = 1'b0;
        exp_o_d  = e;
        zero_d   = 1'b0;
        denorm_d = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.data_in;
                    e_d     = bus.exp_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (m == '0) begin
                    ld      = 1'b1;
                    zero_d  = 1'b1;
                    exp_o_d = '0;
                    state_d = DONE;
                end else if (e == '0) begin
                    ld       = 1'b1;
                    denorm_d = 1'b1;
                    state_d  = DONE;
                end else if (STEP > 1 && top_zero && e > STEP_E) begin
                    // Coarse step only while the exponent can absorb it without dropping below 1.
                    m_d   = m << STEP;
                    e_d   = e - STEP_E;
                    cnt_d = cnt + STEP_C;
                end else if (!m[MSB] && e > ONE_E) begin
                    m_d   = m << 1;
                    e_d   = e - ONE_E;
                    cnt_d = cnt + ONE_C;
                end else begin
                    ld       = 1'b1;
                    denorm_d = ~m[MSB];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: STEP=1 and STEP=4 instances, directed operands.
module tb_seq_normalizer;
    localparam int DW = 32;
    localparam int EW = 8;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_normalizer_if #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) if1 ();
    seq_normalizer_if #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) if4 ();

    seq_normalizer #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    seq_normalizer #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave));

    typedef struct {
        logic [DW-1:0] d;
        logic [EW-1:0] e;
        logic [CW-1:0] c;
        logic          z;
        logic          dn;
        int            lat;
        int            acc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic [DW-1:0] d, logic [EW-1:0] e, logic [CW-1:0] c,
                                logic z, logic dn, int lat);
        exp_t x;
        x.d = d; x.e = e; x.c = c; x.z = z; x.dn = dn; x.lat = lat; x.acc = 0;
        return x;
    endfunction

    task automatic cmp_out(string tag, exp_t x, logic [DW-1:0] d, logic [EW-1:0] e,
                           logic [CW-1:0] c, logic z, logic dn);
        chk({tag, " data_out"}, d, x.d);
        chk({tag, " exp_out"}, e, x.e);
        chk({tag, " shift_cnt"}, c, x.c);
        chk({tag, " zero"}, z, x.z);
        chk({tag, " denorm"}, dn, x.dn);
        chk({tag, " latency"}, cyc - x.acc, x.lat);
    endtask

    // Monitors: pop one expectation each time out_valid rises.
    initial begin
        bit pv = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 0;
            else begin
                if (if1.out_valid && !pv) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut1 unexpected out_valid: got 1 expected 0");
                    end else begin
                        x = q1.pop_front();
                        cmp_out("dut1", x, if1.data_out, if1.exp_out, if1.shift_cnt, if1.zero, if1.denorm);
                    end
                end
                pv = if1.out_valid;
            end
        end
    end

    initial begin
        bit pv = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 0;
            else begin
                if (if4.out_valid && !pv) begin
                    if (q4.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut4 unexpected out_valid: got 1 expected 0");
                    end else begin
                        x = q4.pop_front();
                        cmp_out("dut4", x, if4.data_out, if4.exp_out, if4.shift_cnt, if4.zero, if4.denorm);
                    end
                end
                pv = if4.out_valid;
            end
        end
    end

    task automatic send(int sel, logic [DW-1:0] d, logic [EW-1:0] e, bit push, exp_t x);
        int n = 0;
        @(negedge clk);
        if (sel == 1) begin if1.in_valid = 1'b1; if1.data_in = d; if1.exp_in = e; end
        else          begin if4.in_valid = 1'b1; if4.data_in = d; if4.exp_in = e; end
        while (!((sel == 1) ? if1.in_ready : if4.in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept timeout dut%0d: got in_ready 0 expected 1", sel);
            if1.in_valid = 1'b0; if4.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        x.acc = cyc;
        if (push) begin
            if (sel == 1) q1.push_back(x);
            else          q4.push_back(x);
        end
    endtask

    task automatic drain(int sel);
        int n = 0;
        while ((((sel == 1) ? q1.size() : q4.size()) != 0 ||
                !((sel == 1) ? if1.in_ready : if4.in_ready)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain timeout dut%0d: got pending result expected none", sel);
        end
    endtask

    initial begin
        int n;
        if1.in_valid = 1'b0; if1.data_in = '0; if1.exp_in = '0; if1.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.data_in = '0; if4.exp_in = '0; if4.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst out_valid", if1.out_valid, 0);
        chk("rst data_out", if1.data_out, 0);
        chk("rst exp_out", if1.exp_out, 0);
        chk("rst shift_cnt", if1.shift_cnt, 0);
        chk("rst zero", if1.zero, 0);
        chk("rst denorm", if1.denorm, 0);
        chk("rst in_ready", if1.in_ready, 1);
        rst_n = 1'b1;

        // STEP=1 vectors
        send(1, 32'h0000_0100, 8'd100, 1, mk(32'h8000_0000, 8'd77, 6'd23, 0, 0, 24)); drain(1);
        send(1, 32'h8000_0001, 8'd5,   1, mk(32'h8000_0001, 8'd5,  6'd0,  0, 0, 1));  drain(1);
        send(1, 32'h0000_0000, 8'd50,  1, mk(32'h0000_0000, 8'd0,  6'd0,  1, 0, 1));  drain(1);
        send(1, 32'h0000_0001, 8'd4,   1, mk(32'h0000_0008, 8'd1,  6'd3,  0, 1, 4));  drain(1);
        send(1, 32'h0000_0010, 8'd0,   1, mk(32'h0000_0010, 8'd0,  6'd0,  0, 1, 1));  drain(1);
        send(1, 32'h0000_0001, 8'd1,   1, mk(32'h0000_0001, 8'd1,  6'd0,  0, 1, 1));  drain(1);

        // Back-pressure: result held, busy input ignored
        if1.out_ready = 1'b0;
        send(1, 32'h8000_0001, 8'd5, 1, mk(32'h8000_0001, 8'd5, 6'd0, 0, 0, 1));
        n = 0;
        while (!if1.out_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin if1.in_valid = 1'b1; if1.data_in = 32'h1234; if1.exp_in = 8'd9; end
            chk("stall out_valid", if1.out_valid, 1);
            chk("stall data_out", if1.data_out, 32'h8000_0001);
            chk("stall exp_out", if1.exp_out, 5);
            chk("stall in_ready", if1.in_ready, 0);
        end
        if1.in_valid = 1'b0;
        if1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release in_ready", if1.in_ready, 1);
        chk("release out_valid", if1.out_valid, 0);
        chk("held data_out", if1.data_out, 32'h8000_0001);
        drain(1);

        // Reset mid-shift aborts the operand
        send(1, 32'h0000_0100, 8'd100, 0, mk(32'h8000_0000, 8'd77, 6'd23, 0, 0, 24));
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort out_valid", if1.out_valid, 0);
        chk("abort data_out", if1.data_out, 0);
        chk("abort exp_out", if1.exp_out, 0);
        chk("abort shift_cnt", if1.shift_cnt, 0);
        chk("abort denorm", if1.denorm, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", if1.in_ready, 1);
        repeat (30) @(negedge clk);
        send(1, 32'h8000_0001, 8'd5, 1, mk(32'h8000_0001, 8'd5, 6'd0, 0, 0, 1)); drain(1);

        // STEP=4 vectors
        send(4, 32'h0000_1000, 8'd100, 1, mk(32'h8000_0000, 8'd81, 6'd19, 0, 0, 8)); drain(4);
        send(4, 32'h0800_0000, 8'd100, 1, mk(32'h8000_0000, 8'd96, 6'd4,  0, 0, 2)); drain(4);
        send(4, 32'h0000_0001, 8'd3,   1, mk(32'h0000_0004, 8'd1,  6'd2,  0, 1, 3)); drain(4);
        send(4, 32'h0000_0001, 8'd6,   1, mk(32'h0000_0020, 8'd1,  6'd5,  0, 1, 3)); drain(4);

        chk("q1 empty", q1.size(), 0);
        chk("q4 empty", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
